writeback_unit: RTL and testbench

//  RV32 writeback stage: sole driver of the register-file write port. Merges results

---
 rtl/rv_pkg.sv | 15 +
 rtl/wb_scoreboard.sv | 49 ++++
 rtl/writeback_unit.sv | 118 +++++++++++
 tb/tb_writeback_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV32 writeback types and constants, also used by execute, LSU and MUL-DIV.
package rv_pkg;

  localparam int XLEN         = 32;
  localparam int REG_AW       = 5;
  localparam int NREGS        = 1 << REG_AW;
  localparam int STARVE_LIMIT = 4;
  localparam int WCNT_W       = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// Pending slow-write tracker: one busy bit per architectural register, with
// one set port, one clear port and three read ports for the decode hazard check.
module wb_scoreboard
  import rv_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_set_valid,
  input  logic [REG_AW-1:0] i_set_idx,
  input  logic              i_clr_valid,
  input  logic [REG_AW-1:0] i_clr_idx,
  input  logic [REG_AW-1:0] i_ra_idx,
  input  logic [REG_AW-1:0] i_rb_idx,
  input  logic [REG_AW-1:0] i_rc_idx,
  output logic              o_ra_busy,
  output logic              o_rb_busy,
  output logic              o_rc_busy,
  output logic [NREGS-1:0]  o_busy
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busy_next;

  // The clear is applied before the set so a new issue to the same register wins.
  always_comb begin
    w_busy_next = r_busy;
    if (i_clr_valid) begin
      w_busy_next[i_clr_idx] = 1'b0;
    end
    if (i_set_valid && (i_set_idx != '0)) begin
      w_busy_next[i_set_idx] = 1'b1;
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign o_ra_busy = (i_ra_idx != '0) && r_busy[i_ra_idx];
  assign o_rb_busy = (i_rb_idx != '0) && r_busy[i_rb_idx];
  assign o_rc_busy = (i_rc_idx != '0) && r_busy[i_rc_idx];
  assign o_busy    = r_busy;

endmodule

// File: rtl/writeback_unit.sv
// RV32 writeback stage: arbitrates the fast ALU and slow load/MUL-DIV results onto the
// single register-file write port, tracks slow destinations and forwards the in-flight write.
module writeback_unit
  import rv_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_fast_valid,
  input  logic [REG_AW-1:0] i_fast_rd,
  input  logic [XLEN-1:0]   i_fast_data,
  output logic              o_fast_ready,
  input  logic              i_slow_valid,
  input  logic [REG_AW-1:0] i_slow_rd,
  input  logic [XLEN-1:0]   i_slow_data,
  output logic              o_slow_ready,
  input  logic              i_issue_valid,
  input  logic [REG_AW-1:0] i_issue_rd,
  input  logic [REG_AW-1:0] i_rs1,
  input  logic [REG_AW-1:0] i_rs2,
  input  logic [REG_AW-1:0] i_rd,
  output logic              o_stall,
  output logic              o_fwd1_hit,
  output logic [XLEN-1:0]   o_fwd1_data,
  output logic              o_fwd2_hit,
  output logic [XLEN-1:0]   o_fwd2_data,
  output logic              o_write,
  output logic [REG_AW-1:0] o_waddr,
  output logic [XLEN-1:0]   o_wdata,
  output logic [NREGS-1:0]  o_busy
);

  localparam logic [WCNT_W-1:0] STARVE_CNT = WCNT_W'(STARVE_LIMIT);

  logic [WCNT_W-1:0] r_wait_cnt;
  logic              r_write;
  logic [REG_AW-1:0] r_waddr;
  logic [XLEN-1:0]   r_wdata;

  logic    w_starved;
  logic    w_fast_acc;
  logic    w_slow_acc;
  logic    w_rs1_busy;
  logic    w_rs2_busy;
  logic    w_rd_busy;
  wb_req_t w_sel;

  // Fast path has priority until the slow path has been blocked long enough.
  assign w_starved    = (r_wait_cnt >= STARVE_CNT);
  assign o_fast_ready = !i_rst && !(w_starved && i_slow_valid);
  assign o_slow_ready = !i_rst && (!i_fast_valid || w_starved);
  assign w_fast_acc   = i_fast_valid && o_fast_ready;
  assign w_slow_acc   = i_slow_valid && o_slow_ready;

  always_comb begin
    w_sel = '0;
    if (w_slow_acc) begin
      w_sel.rd   = i_slow_rd;
      w_sel.data = i_slow_data;
    end else if (w_fast_acc) begin
      w_sel.rd   = i_fast_rd;
      w_sel.data = i_fast_data;
    end
  end

  // A result headed for x0 still completes its handshake but never writes.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_write <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else if (w_slow_acc || w_fast_acc) begin
      r_write <= (w_sel.rd != '0);
      r_waddr <= w_sel.rd;
      r_wdata <= w_sel.data;
    end else begin
      r_write <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wait_cnt <= '0;
    end else if (!i_slow_valid || w_slow_acc) begin
      r_wait_cnt <= '0;
    end else if (!w_starved) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

  wb_scoreboard u_scoreboard (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_set_valid (i_issue_valid),
    .i_set_idx   (i_issue_rd),
    .i_clr_valid (w_slow_acc),
    .i_clr_idx   (i_slow_rd),
    .i_ra_idx    (i_rs1),
    .i_rb_idx    (i_rs2),
    .i_rc_idx    (i_rd),
    .o_ra_busy   (w_rs1_busy),
    .o_rb_busy   (w_rs2_busy),
    .o_rc_busy   (w_rd_busy),
    .o_busy      (o_busy)
  );

  assign o_stall = w_rs1_busy | w_rs2_busy | w_rd_busy;

  // Covers the one cycle where the write is on the port but not yet in the register file.
  assign o_fwd1_hit  = r_write && (r_waddr == i_rs1) && (i_rs1 != '0);
  assign o_fwd2_hit  = r_write && (r_waddr == i_rs2) && (i_rs2 != '0);
  assign o_fwd1_data = r_wdata;
  assign o_fwd2_data = r_wdata;

  assign o_write = r_write;
  assign o_waddr = r_waddr;
  assign o_wdata = r_wdata;

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: reset, fast/slow writes, forwarding, stall,
// starvation arbitration, x0 handling and scoreboard set-over-clear.
module tb_writeback_unit;

  logic        i_clk;
  logic        i_rst;
  logic        i_fast_valid;
  logic [4:0]  i_fast_rd;
  logic [31:0] i_fast_data;
  logic        o_fast_ready;
  logic        i_slow_valid;
  logic [4:0]  i_slow_rd;
  logic [31:0] i_slow_data;
  logic        o_slow_ready;
  logic        i_issue_valid;
  logic [4:0]  i_issue_rd;
  logic [4:0]  i_rs1;
  logic [4:0]  i_rs2;
  logic [4:0]  i_rd;
  logic        o_stall;
  logic        o_fwd1_hit;
  logic [31:0] o_fwd1_data;
  logic        o_fwd2_hit;
  logic [31:0] o_fwd2_data;
  logic        o_write;
  logic [4:0]  o_waddr;
  logic [31:0] o_wdata;
  logic [31:0] o_busy;

  int passCount = 0;
  int checkCount = 0;

  writeback_unit dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_fast_valid  (i_fast_valid),
    .i_fast_rd     (i_fast_rd),
    .i_fast_data   (i_fast_data),
    .o_fast_ready  (o_fast_ready),
    .i_slow_valid  (i_slow_valid),
    .i_slow_rd     (i_slow_rd),
    .i_slow_data   (i_slow_data),
    .o_slow_ready  (o_slow_ready),
    .i_issue_valid (i_issue_valid),
    .i_issue_rd    (i_issue_rd),
    .i_rs1         (i_rs1),
    .i_rs2         (i_rs2),
    .i_rd          (i_rd),
    .o_stall       (o_stall),
    .o_fwd1_hit    (o_fwd1_hit),
    .o_fwd1_data   (o_fwd1_data),
    .o_fwd2_hit    (o_fwd2_hit),
    .o_fwd2_data   (o_fwd2_data),
    .o_write       (o_write),
    .o_waddr       (o_waddr),
    .o_wdata       (o_wdata),
    .o_busy        (o_busy)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
  endtask

  // Advance past the next rising edge; inputs change and registered outputs are sampled 1ns later.
  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    i_rst = 1'b1;
    i_fast_valid = 1'b1; i_fast_rd = 5'd4; i_fast_data = 32'h1111_1111;
    i_slow_valid = 1'b1; i_slow_rd = 5'd6; i_slow_data = 32'h2222_2222;
    i_issue_valid = 1'b1; i_issue_rd = 5'd9;
    i_rs1 = '0; i_rs2 = '0; i_rd = '0;

    // Reset with every valid raised
    settle();
    checkOutput("rst_fast_ready", 64'(o_fast_ready), 64'd0);
    checkOutput("rst_slow_ready", 64'(o_slow_ready), 64'd0);
    tick();
    checkOutput("rst_write_c1", 64'(o_write), 64'd0);
    checkOutput("rst_busy_c1", 64'(o_busy), 64'd0);
    tick();
    checkOutput("rst_write_c2", 64'(o_write), 64'd0);
    checkOutput("rst_waddr", 64'(o_waddr), 64'd0);
    checkOutput("rst_wdata", 64'(o_wdata), 64'd0);
    checkOutput("rst_busy_c2", 64'(o_busy), 64'd0);
    i_rst = 1'b0;
    i_fast_valid = 1'b0; i_slow_valid = 1'b0; i_issue_valid = 1'b0;
    tick();
    checkOutput("post_rst_write", 64'(o_write), 64'd0);
    checkOutput("post_rst_busy", 64'(o_busy), 64'd0);

    // Fast write and rs1 forwarding
    i_fast_valid = 1'b1; i_fast_rd = 5'd5; i_fast_data = 32'hDEAD_BEEF;
    settle();
    checkOutput("fast_ready", 64'(o_fast_ready), 64'd1);
    tick();
    i_fast_valid = 1'b0;
    i_rs1 = 5'd5;
    settle();
    checkOutput("fast_write", 64'(o_write), 64'd1);
    checkOutput("fast_waddr", 64'(o_waddr), 64'd5);
    checkOutput("fast_wdata", 64'(o_wdata), 64'hDEAD_BEEF);
    checkOutput("fwd1_hit", 64'(o_fwd1_hit), 64'd1);
    checkOutput("fwd1_data", 64'(o_fwd1_data), 64'hDEAD_BEEF);
    checkOutput("fwd2_nohit_x0", 64'(o_fwd2_hit), 64'd0);
    checkOutput("fast_busy_untouched", 64'(o_busy), 64'd0);
    tick();
    checkOutput("idle_write", 64'(o_write), 64'd0);
    checkOutput("idle_waddr_hold", 64'(o_waddr), 64'd5);
    checkOutput("idle_fwd1_miss", 64'(o_fwd1_hit), 64'd0);
    i_rs1 = '0;

    // Slow issue, stall on rs2, then slow completion clears the stall
    i_issue_valid = 1'b1; i_issue_rd = 5'd7;
    tick();
    i_issue_valid = 1'b0;
    i_rs2 = 5'd7;
    settle();
    checkOutput("issue_busy7", 64'(o_busy), 64'h80);
    checkOutput("stall_rs2", 64'(o_stall), 64'd1);
    i_slow_valid = 1'b1; i_slow_rd = 5'd7; i_slow_data = 32'h0000_1234;
    settle();
    checkOutput("slow_ready", 64'(o_slow_ready), 64'd1);
    tick();
    i_slow_valid = 1'b0;
    settle();
    checkOutput("slow_busy_clear", 64'(o_busy), 64'd0);
    checkOutput("slow_stall_clear", 64'(o_stall), 64'd0);
    checkOutput("slow_write", 64'(o_write), 64'd1);
    checkOutput("slow_waddr", 64'(o_waddr), 64'd7);
    checkOutput("slow_wdata", 64'(o_wdata), 64'h1234);
    checkOutput("fwd2_hit", 64'(o_fwd2_hit), 64'd1);
    checkOutput("fwd2_data", 64'(o_fwd2_data), 64'h1234);
    i_rs2 = '0;
    tick();

    // Continuous contention: fast wins four cycles, slow the fifth, fast the sixth
    i_fast_valid = 1'b1; i_fast_rd = 5'd1;
    i_slow_valid = 1'b1; i_slow_rd = 5'd2; i_slow_data = 32'h5555_5555;
    for (int i = 0; i < 6; i++) begin
      i_fast_data = 32'd100 + 32'(i);
      settle();
      checkOutput($sformatf("arb_fast_ready_%0d", i), 64'(o_fast_ready), (i == 4) ? 64'd0 : 64'd1);
      checkOutput($sformatf("arb_slow_ready_%0d", i), 64'(o_slow_ready), (i == 4) ? 64'd1 : 64'd0);
      tick();
      checkOutput($sformatf("arb_waddr_%0d", i), 64'(o_waddr), (i == 4) ? 64'd2 : 64'd1);
      checkOutput($sformatf("arb_wdata_%0d", i), 64'(o_wdata),
                  (i == 4) ? 64'h5555_5555 : 64'd100 + 64'(i));
    end
    i_fast_valid = 1'b0; i_slow_valid = 1'b0;
    tick();

    // Destination x0 on every path
    i_fast_valid = 1'b1; i_fast_rd = 5'd0; i_fast_data = 32'h0000_00AA;
    i_issue_valid = 1'b1; i_issue_rd = 5'd0;
    settle();
    checkOutput("x0_fast_ready", 64'(o_fast_ready), 64'd1);
    tick();
    i_fast_valid = 1'b0; i_issue_valid = 1'b0;
    checkOutput("x0_fast_nowrite", 64'(o_write), 64'd0);
    checkOutput("x0_issue_busy", 64'(o_busy), 64'd0);
    i_slow_valid = 1'b1; i_slow_rd = 5'd0; i_slow_data = 32'h0000_00BB;
    settle();
    checkOutput("x0_slow_ready", 64'(o_slow_ready), 64'd1);
    tick();
    i_slow_valid = 1'b0;
    checkOutput("x0_slow_nowrite", 64'(o_write), 64'd0);
    checkOutput("x0_slow_busy", 64'(o_busy), 64'd0);

    // Re-issue to x3 in the same cycle x3 completes: set wins
    i_issue_valid = 1'b1; i_issue_rd = 5'd3;
    tick();
    i_rd = 5'd3;
    settle();
    checkOutput("sb_busy3", 64'(o_busy), 64'h8);
    checkOutput("stall_waw", 64'(o_stall), 64'd1);
    i_slow_valid = 1'b1; i_slow_rd = 5'd3; i_slow_data = 32'h0000_0033;
    tick();
    i_issue_valid = 1'b0;
    settle();
    checkOutput("sb_set_wins", 64'(o_busy), 64'h8);
    checkOutput("sb_set_wins_write", 64'(o_waddr), 64'd3);
    tick();
    i_slow_valid = 1'b0;
    settle();
    checkOutput("sb_final_clear", 64'(o_busy), 64'd0);
    checkOutput("sb_final_stall", 64'(o_stall), 64'd0);
    i_rd = '0;

    // Reset mid-operation drops pending busy bits
    i_issue_valid = 1'b1; i_issue_rd = 5'd12;
    tick();
    i_issue_valid = 1'b0;
    checkOutput("mid_busy12", 64'(o_busy), 64'h1000);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    checkOutput("mid_rst_busy", 64'(o_busy), 64'd0);
    checkOutput("mid_rst_write", 64'(o_write), 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
